// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: byte-lane writes, read-after-write bypass, two-cycle ERROR response.
// Define AHB_SLV_WAIT_EN to insert WAIT_STATES wait cycles into every legal data phase.
module ahb_mem_slave #(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [2:0]  dbg_state
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_WAIT = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            hready_q, hready_d;
  logic            hresp_q, hresp_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [1:0]      size_q, size_d;
`ifdef AHB_SLV_WAIT_EN
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  logic [CW-1:0]   cnt_q, cnt_d;
`endif

  logic [31:0]     mem_q [MEM_WORDS];
  logic            acc, illegal, commit_wr;
  logic [AW-1:0]   wr_idx, rd_idx;
  logic [3:0]      wr_mask;
  logic [31:0]     rd_word;
  logic            unused_ok;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Handshake: an address phase is taken on a rising edge where HSEL, HREADY and
  // HTRANS[1] are all high; its data phase ends on the first cycle with HREADYOUT=1.
  assign acc     = HSEL && HREADY && HTRANS[1];
  assign illegal = (HSIZE > 3'd2) ||
                   ((HSIZE == 3'd1) && HADDR[0]) ||
                   ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) ||
                   ({1'b0, HADDR} >= ADDR_LIMIT);

  assign commit_wr = hready_q && write_q && (state_q == ST_DATA || state_q == ST_WAIT);
  assign wr_idx    = addr_q[AW+1:2];
  assign wr_mask   = lane_mask(size_q, addr_q[1:0]);
  assign rd_idx    = hready_q ? HADDR[AW+1:2] : addr_q[AW+1:2];

  // Merge bytes committing this cycle so a back-to-back read sees them.
  always_comb begin
    rd_word = mem_q[rd_idx];
    if (commit_wr && (wr_idx == rd_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    hready_d = hready_q;
    hresp_d  = hresp_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
`ifdef AHB_SLV_WAIT_EN
    cnt_d    = cnt_q;
`endif
    if (hready_q) begin
      if (acc && illegal) begin
        state_d  = ST_ERR1;
        hready_d = 1'b0;
        hresp_d  = 1'b1;
        write_d  = 1'b0;
      end else if (acc) begin
        state_d = ST_DATA;
        hresp_d = 1'b0;
        addr_d  = HADDR[AW+1:0];
        write_d = HWRITE;
        size_d  = HSIZE[1:0];
`ifdef AHB_SLV_WAIT_EN
        hready_d = (WAIT_STATES == 0);
        cnt_d    = CW'(WAIT_STATES);
        if ((WAIT_STATES == 0) && !HWRITE) rdata_d = rd_word;
`else
        hready_d = 1'b1;
        if (!HWRITE) rdata_d = rd_word;
`endif
      end else begin
        state_d  = ST_IDLE;
        hready_d = 1'b1;
        hresp_d  = 1'b0;
        write_d  = 1'b0;
      end
    end else begin
      case (state_q)
        ST_ERR1: begin
          state_d  = ST_ERR2;
          hready_d = 1'b1;
          hresp_d  = 1'b1;
        end
`ifdef AHB_SLV_WAIT_EN
        // DATA and WAIT both count down; the cycle with count zero is the final one.
        ST_DATA, ST_WAIT: begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q - CW'(1);
          if (cnt_d == '0) begin
            hready_d = 1'b1;
            if (!write_q) rdata_d = rd_word;
          end
        end
`endif
        default: begin
          state_d  = ST_IDLE;
          hready_d = 1'b1;
          hresp_d  = 1'b0;
          write_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
`ifdef AHB_SLV_WAIT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
`ifdef AHB_SLV_WAIT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Storage is never reset; a reset edge also cancels the pending write.
  always_ff @(posedge HCLK) begin
    if (HRESETn && commit_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem_q[wr_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA    = rdata_q;
  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;
  assign dbg_state = state_q;
  assign unused_ok = ^{HTRANS[0], HBURST} ^ (WAIT_STATES < 0);

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Randomized scoreboard bench for ahb_mem_slave against a byte-array memory model.
module tb_ahb_mem_slave;
  localparam int MW = 256;
  localparam int WS = 2;
`ifdef AHB_SLV_WAIT_EN
  localparam int EXP_WAITS = WS;
`else
  localparam int EXP_WAITS = 0;
`endif
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  typedef struct packed {
    logic        err;
    logic        rd;
    logic [31:0] data;
    logic [7:0]  waits;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [1:0]  htrans = T_IDLE;
  logic [2:0]  hburst = '0;
  logic [31:0] hwdata = '0;
  logic [31:0] hrdata;
  logic        hreadyout, hresp;
  logic [2:0]  dbg_state;

  exp_t        exp_q[$];
  logic [7:0]  ref_bytes [4*MW];
  int          n_tests = 0;
  int          n_fail = 0;
  bit          abort_mode = 1'b1;

  ahb_mem_slave #(.MEM_WORDS(MW), .WAIT_STATES(WS)) dut (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HTRANS(htrans), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hreadyout), .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp),
    .dbg_state(dbg_state)
  );

  // Clock/reset
  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b0;
    if (a >= 32'(4 * MW)) return 1'b0;
    if ((a % (32'd1 << s)) != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_ready();
    int n = 0;
    forever begin
      @(negedge hclk);
      if (hreadyout) break;
      n++;
      if (n > 50) begin
        n_fail++;
        $display("FAIL ready_timeout: HREADYOUT stuck at %b", hreadyout);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "bus hang");
      end
    end
    @(posedge hclk);
    #1;
  endtask

  // Driver: one address phase; model is updated in issue order.
  task automatic xfer(input logic sel, input logic [1:0] trans, input logic write,
                      input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] burst = 3'b000);
    exp_t e;
    int unsigned w;
    hsel = sel; htrans = trans; hwrite = write; hsize = size; haddr = addr; hburst = burst;
    if (sel && trans[1]) begin
      e = '0;
      e.err = !is_legal(addr, size);
      e.rd = !write;
      e.waits = e.err ? 8'd1 : 8'(EXP_WAITS);
      if (!e.err) begin
        if (write) begin
          for (int i = 0; i < (1 << size); i++)
            ref_bytes[addr + i] = wdata[8*((addr + i) % 4) +: 8];
        end else begin
          w = addr - (addr % 4);
          e.data = {ref_bytes[w+3], ref_bytes[w+2], ref_bytes[w+1], ref_bytes[w]};
        end
      end
      exp_q.push_back(e);
    end
    wait_ready();
    hwdata = wdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) xfer(1'b1, T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    bit          pending = 1'b0;
    bit          rd_final;
    int          waits = 0;
    logic [31:0] last_rd = '0;
    exp_t        cur;
    forever begin
      @(negedge hclk);
      if (abort_mode || !hresetn) begin
        pending = 1'b0; waits = 0; last_rd = '0;
        continue;
      end
      rd_final = 1'b0;
      if (pending) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL queue_underflow: data phase seen with no expected entry");
          pending = 1'b0;
        end else begin
          cur = exp_q[0];
          check("hresp", 32'(hresp), 32'(cur.err));
          if (!hreadyout) waits++;
          else begin
            void'(exp_q.pop_front());
            check("wait_cycles", waits, 32'(cur.waits));
            if (cur.rd && !cur.err) begin
              check("hrdata", hrdata, cur.data);
              last_rd = cur.data;
              rd_final = 1'b1;
            end
            waits = 0;
            pending = 1'b0;
          end
        end
      end else begin
        check("idle_hreadyout", 32'(hreadyout), 32'd1);
        check("idle_hresp", 32'(hresp), 32'd0);
      end
      if (!rd_final) check("hrdata_hold", hrdata, last_rd);
      if (hsel && hreadyout && htrans[1]) pending = 1'b1;
    end
  end

  initial begin : stimulus
    logic [31:0] a;
    logic [2:0]  s;
    int          r;
    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(negedge hclk);
    check("reset_hreadyout", 32'(hreadyout), 32'd1);
    check("reset_hresp", 32'(hresp), 32'd0);
    check("reset_hrdata", hrdata, 32'h0);
    abort_mode = 1'b0;
    @(posedge hclk); #1;

    // Known contents: zero the low region and the top two words (pipelined burst).
    for (int w = 0; w < 64; w++)
      xfer(1'b1, (w == 0) ? T_NSEQ : T_SEQ, 1'b1, 3'd2, 32'(w * 4), 32'h0, 3'b001);
    xfer(1'b1, T_NSEQ, 1'b1, 3'd2, 32'(4 * MW - 8), 32'h0);
    xfer(1'b1, T_SEQ,  1'b1, 3'd2, 32'(4 * MW - 4), 32'h0);
    idle(2);

    // Byte writes then word read (expects 0x0000B600).
    xfer(1'b1, T_NSEQ, 1'b1, 3'd0, 32'h00, 32'h000000A5);
    xfer(1'b1, T_NSEQ, 1'b1, 3'd0, 32'h05, 32'h0000B600);
    xfer(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h04, 32'h0);
    idle(2);

    // Halfword write immediately followed by read of the same word (bypass).
    xfer(1'b1, T_NSEQ, 1'b1, 3'd1, 32'h10, 32'h0000A5B6);
    xfer(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    idle(1);

    // Misaligned halfword, out-of-range, oversize, then IDLE/BUSY with HSEL=1.
    xfer(1'b1, T_NSEQ, 1'b1, 3'd1, 32'h11, 32'hFFFF_FFFF);
    xfer(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    xfer(1'b1, T_NSEQ, 1'b0, 3'd2, 32'(4 * MW), 32'h0);
    xfer(1'b1, T_NSEQ, 1'b1, 3'd3, 32'h18, 32'h1234_5678);
    xfer(1'b1, T_IDLE, 1'b1, 3'd2, 32'h10, 32'hFFFF_FFFF);
    xfer(1'b1, T_BUSY, 1'b1, 3'd2, 32'h10, 32'hEEEE_EEEE);
    xfer(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    xfer(1'b1, T_NSEQ, 1'b0, 3'd2, 32'(4 * MW - 4), 32'h0);
    idle(2);

    // Two-beat word burst and readback.
    xfer(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h50, 32'h1111_1111, 3'b001);
    xfer(1'b1, T_SEQ,  1'b1, 3'd2, 32'h54, 32'h2222_2222, 3'b001);
    xfer(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h50, 32'h0, 3'b001);
    xfer(1'b1, T_SEQ,  1'b0, 3'd2, 32'h54, 32'h0, 3'b001);
    idle(2);

    // Reset in the middle of a write data phase must drop the write.
    xfer(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h20, 32'hCAFE_0001);
    idle(2);
    abort_mode = 1'b1;
    hsel = 1'b1; htrans = T_NSEQ; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h20;
    wait_ready();
    hwdata = 32'hDEAD_BEEF;
    htrans = T_IDLE;
`ifdef AHB_SLV_WAIT_EN
    @(posedge hclk); #1;
`endif
    hresetn = 1'b0;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(negedge hclk);
    check("abort_hreadyout", 32'(hreadyout), 32'd1);
    check("abort_hresp", 32'(hresp), 32'd0);
    check("abort_hrdata", hrdata, 32'h0);
    abort_mode = 1'b0;
    @(posedge hclk); #1;
    xfer(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h20, 32'h0);
    idle(1);

    // Random traffic.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      s = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3;
      if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(4 * MW - 8, 4 * MW + 8));
      else a = 32'($urandom_range(0, 255));
      if ((s < 3'd3) && ($urandom_range(0, 3) != 0)) a = a & ~((32'd1 << s) - 32'd1);
      xfer(($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           s, a, $urandom(), 3'($urandom_range(0, 7)));
    end
    idle(4);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge hclk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
